// File: rtl/filter_pkg.sv
// Shared encodings and column-index helpers for the filter window generator.
package filter_pkg;

    typedef enum logic [1:0] {
        BM_MIRROR_ND = 2'd0,
        BM_REPLICATE = 2'd1,
        BM_ZERO      = 2'd2,
        BM_MIRROR    = 2'd3
    } border_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    function automatic int calc_radius(input int w);
        return (w - 1) / 2;
    endfunction

    // Maps a possibly out-of-line source column onto a real column of the line.
    function automatic int map_col(input int x, input int n, input border_mode_e mode);
        if (x < 0)
            return (mode == BM_REPLICATE) ? 0 : -x;
        if (x > n - 1)
            return (mode == BM_REPLICATE) ? n - 1 : 2 * (n - 1) - x;
        return x;
    endfunction

endpackage

// File: rtl/filter_window_gen_if.sv
// Column-in / window-out handshake bundle of filter_window_gen.
interface filter_window_gen_if #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int IMG_WIDTH  = 640
);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [PIX_BIT*MASK_WIDTH-1:0]            in_col;
    logic                                     in_valid;
    logic                                     in_ready;
    logic                                     in_sol;
    logic [1:0]                               border_mode;
    logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] win_out;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [CW-1:0]                            out_center;
    logic                                     err_line;

    modport master (
        output in_col, in_valid, in_sol, border_mode, out_ready,
        input  in_ready, win_out, out_valid, out_center, err_line
    );

    modport slave (
        input  in_col, in_valid, in_sol, border_mode, out_ready,
        output in_ready, win_out, out_valid, out_center, err_line
    );

endinterface

// File: rtl/filter_border_mux.sv
// One window row: picks W taps from the column history (tap m = column base-m).
// Zero injection exists only when FILTER_WIN_ZERO_PAD_EN is defined.
import filter_pkg::*;

module filter_border_mux #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int IMG_WIDTH  = 640,
    parameter int CENTER_W   = 10,
    parameter int BASE_W     = 10
) (
    input  logic [PIX_BIT*MASK_WIDTH-1:0] i_src,
    input  logic [CENTER_W-1:0]           i_center,
    input  logic [BASE_W-1:0]             i_base,
    input  border_mode_e                  i_mode,
    output logic [PIX_BIT*MASK_WIDTH-1:0] o_taps
);
    localparam int W = MASK_WIDTH;
    localparam int R = calc_radius(MASK_WIDTH);
    localparam int N = IMG_WIDTH;

    always_comb begin : p_map
        int x;
        int xm;
        int m;
        x      = 0;
        xm     = 0;
        m      = 0;
        o_taps = '0;
        for (int i = 0; i < W; i++) begin
            x  = int'(i_center) + R - i;
            xm = map_col(x, N, i_mode);
            m  = int'(i_base) - xm;
            for (int k = 0; k < W; k++) begin
                if (m == k)
                    o_taps[i*PIX_BIT +: PIX_BIT] = i_src[k*PIX_BIT +: PIX_BIT];
            end
`ifdef FILTER_WIN_ZERO_PAD_EN
            if (i_mode == BM_ZERO && (x < 0 || x > N - 1))
                o_taps[i*PIX_BIT +: PIX_BIT] = '0;
`endif
        end
    end

endmodule

// File: rtl/filter_window_gen.sv
// Sliding WxW window generator over a column stream with border handling.
// Optional zero padding for border_mode 2: define FILTER_WIN_ZERO_PAD_EN.
import filter_pkg::*;

module filter_window_gen #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int IMG_WIDTH  = 640
) (
    input  logic               clk,
    input  logic               reset,
    filter_window_gen_if.slave bus
);
    localparam int W  = MASK_WIDTH;
    localparam int R  = calc_radius(MASK_WIDTH);
    localparam int N  = IMG_WIDTH;
    localparam int PW = PIX_BIT * W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = $clog2(N + 1);
    localparam logic [KW-1:0] R_K    = KW'(R);
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);
    localparam logic [CW-1:0] PEN_C  = CW'(N - 2);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    function automatic border_mode_e eff_mode(input logic [1:0] m);
        case (m)
            2'd1:    return BM_REPLICATE;
`ifdef FILTER_WIN_ZERO_PAD_EN
            2'd2:    return BM_ZERO;
`endif
            default: return BM_MIRROR_ND;
        endcase
    endfunction

    state_e        r_state, w_state_nx;
    logic [KW-1:0] r_col_cnt, w_col_cnt_nx;
    border_mode_e  r_mode, w_mode_nx;
    logic          r_vld_p1, w_vld_nx;
    logic [CW-1:0] r_center_p1, w_center_nx;
    logic          r_err, w_err_nx;
    logic [PW-1:0] r_hist [W];
    logic [PW*W-1:0] r_win_p1, w_win;
    logic [PW-1:0] w_src [W];
    logic [KW-1:0] w_base;
    logic          w_stall, w_acc, w_ld, w_flush_src;

    assign w_stall      = r_vld_p1 && !bus.out_ready;
    assign bus.in_ready = reset && (r_state != ST_FLUSH) && !w_stall;
    assign w_acc        = bus.in_valid && bus.in_ready;
    assign w_base       = w_flush_src ? LAST_K : r_col_cnt;

    always_comb begin
        w_state_nx   = r_state;
        w_col_cnt_nx = r_col_cnt;
        w_mode_nx    = r_mode;
        w_vld_nx     = r_vld_p1;
        w_center_nx  = r_center_p1;
        w_err_nx     = 1'b0;
        w_ld         = 1'b0;
        w_flush_src  = 1'b0;
        if (!w_stall) begin
            w_vld_nx = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc && bus.in_sol) begin
                        w_state_nx   = ST_FILL;
                        w_col_cnt_nx = KW'(1);
                        w_mode_nx    = eff_mode(bus.border_mode);
                    end else if (w_acc) begin
                        w_err_nx = 1'b1;
                    end
                end
                ST_FILL, ST_RUN: begin
                    if (w_acc && bus.in_sol) begin
                        w_state_nx   = ST_FILL;
                        w_col_cnt_nx = KW'(1);
                        w_mode_nx    = eff_mode(bus.border_mode);
                        w_err_nx     = 1'b1;
                    end else if (w_acc) begin
                        w_col_cnt_nx = r_col_cnt + KW'(1);
                        // Column k completes the window centred R columns back.
                        if (r_col_cnt >= R_K) begin
                            w_ld        = 1'b1;
                            w_vld_nx    = 1'b1;
                            w_center_nx = CW'(r_col_cnt - R_K);
                            w_state_nx  = (r_col_cnt == LAST_K) ? ST_FLUSH : ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    w_flush_src = 1'b1;
                    w_ld        = 1'b1;
                    w_vld_nx    = 1'b1;
                    w_center_nx = r_center_p1 + ONE_C;
                    if (r_center_p1 == PEN_C) begin
                        w_state_nx   = ST_IDLE;
                        w_col_cnt_nx = '0;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_col_cnt   <= '0;
            r_mode      <= BM_MIRROR_ND;
            r_vld_p1    <= 1'b0;
            r_center_p1 <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_col_cnt   <= w_col_cnt_nx;
            r_mode      <= w_mode_nx;
            r_vld_p1    <= w_vld_nx;
            r_center_p1 <= w_center_nx;
            r_err       <= w_err_nx;
        end
    end

    // Stage p1: raw column history and registered window, no reset on data.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_hist[0] <= bus.in_col;
            for (int m = 1; m < W; m++)
                r_hist[m] <= r_hist[m-1];
        end
        if (w_ld)
            r_win_p1 <= w_win;
    end

    // During a flush the history already ends at column N-1; otherwise the incoming column is newest.
    for (genvar m = 0; m < W; m++) begin : g_src
        if (m == 0) begin : g_new
            assign w_src[m] = w_flush_src ? r_hist[0] : bus.in_col;
        end else begin : g_old
            assign w_src[m] = w_flush_src ? r_hist[m] : r_hist[m-1];
        end
    end

    for (genvar j = 0; j < W; j++) begin : g_row
        logic [PW-1:0] w_row_src;
        for (genvar m = 0; m < W; m++) begin : g_pix
            assign w_row_src[m*PIX_BIT +: PIX_BIT] = w_src[m][j*PIX_BIT +: PIX_BIT];
        end
        filter_border_mux #(
            .PIX_BIT   (PIX_BIT),
            .MASK_WIDTH(MASK_WIDTH),
            .IMG_WIDTH (IMG_WIDTH),
            .CENTER_W  (CW),
            .BASE_W    (KW)
        ) u_mux (
            .i_src   (w_row_src),
            .i_center(w_center_nx),
            .i_base  (w_base),
            .i_mode  (r_mode),
            .o_taps  (w_win[j*PW +: PW])
        );
    end

    assign bus.win_out    = r_win_p1;
    assign bus.out_valid  = r_vld_p1;
    assign bus.out_center = r_center_p1;
    assign bus.err_line   = r_err;

endmodule
